sseg_scan_mux: RTL and testbench

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. It holds a 16-bit display value and cycles through its four hex nibbles. For each nibble it presents the value on `digit` to the downstream hex-to-segment decoder and drives the matching active-low anode and decimal point. Updates are double-buffered and swap only at frame boundaries, so a new value never tears across digits. It also supports leading-zero blanking and an anode dead-time at the start of each digit slot to suppress ghosting.

---
 rtl/sseg_scan_mux.sv | 104 ++++++++++
 tb/tb_sseg_scan_mux.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sseg_scan_mux.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// It double-buffers the display value, blanks leading zeros, and turns all anodes off at the start of each slot.
module sseg_scan_mux #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    sel;
  logic [15:0]   act_val, pend_val;
  logic [3:0]    act_dp, pend_dp;
  logic          pend_v;

  logic slot_end, wrap;
  logic dead, lz_hit, blank;

  assign slot_end = (cnt == CW'(CLK_DIV - 1));
  assign wrap     = slot_end && (sel == 2'd3);

  // The count and the digit index advance together, so a slot is exactly CLK_DIV cycles long.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sel <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      sel <= sel + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // The pending buffer reaches the active buffer only on the 3->0 wrap.
  // A load on the wrap edge skips the pending buffer and goes straight to the active buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_val  <= '0;
      act_dp   <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      pend_v   <= 1'b0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end
      if (wrap) begin
        pend_v <= 1'b0;
        if (load) begin
          act_val <= value;
          act_dp  <= dp_in;
        end else if (pend_v) begin
          act_val <= pend_val;
          act_dp  <= pend_dp;
        end
      end else if (load) begin
        pend_v <= 1'b1;
      end
    end
  end

  // The dead-time compare uses a signed int so that BLANK_CYCLES = 0 is not a constant-false unsigned compare.
  assign dead = (int'(cnt) < BLANK_CYCLES);

  always_comb begin
    lz_hit = 1'b0;
    case (sel)
      2'd1:    lz_hit = (act_val[15:4]  == 12'd0);
      2'd2:    lz_hit = (act_val[15:8]  == 8'd0);
      2'd3:    lz_hit = (act_val[15:12] == 4'd0);
      default: lz_hit = 1'b0;
    endcase
    blank = dead || (lz_blank && lz_hit);
  end

  // The outputs are registered from the pre-edge state, so they lag cnt and sel by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= '0;
      an    <= 4'b1111;
      dp    <= 1'b1;
      frame <= 1'b0;
    end else begin
      digit <= act_val[{sel, 2'b00} +: 4];
      an    <= blank ? 4'b1111 : ~(4'b0001 << sel);
      dp    <= blank ? 1'b1 : ~act_dp[sel];
      frame <= wrap;
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux with CLK_DIV=4 and BLANK_CYCLES=1.
// Every expected output is written out by hand, slot by slot.
module tb_sseg_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_blank = 1'b0;
  logic [3:0]  digit, an;
  logic        dp, frame;

  int checks = 0;
  int errors = 0;

  sseg_scan_mux #(.CLK_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .lz_blank(lz_blank), .digit(digit), .an(an), .dp(dp), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an_e, input logic [3:0] dig_e,
                         input logic dp_e, input logic fr_e);
    chk({tag, ".an"},    16'(an),    16'(an_e));
    chk({tag, ".digit"}, 16'(digit), 16'(dig_e));
    chk({tag, ".dp"},    16'(dp),    16'(dp_e));
    chk({tag, ".frame"}, 16'(frame), 16'(fr_e));
  endtask

  // Sample 1 time unit after the edge. Any load pulse set up by the caller is dropped here.
  task automatic tick_chk(input string tag, input logic [3:0] an_e, input logic [3:0] dig_e,
                          input logic dp_e, input logic fr_e);
    @(posedge clk); #1;
    load = 1'b0;
    chk_out(tag, an_e, dig_e, dp_e, fr_e);
  endtask

  // One slot: one dead-time cycle, then three lit cycles. frame can only be high on the last cycle.
  task automatic slot(input string tag, input logic [3:0] an_e, input logic [3:0] dig_e,
                      input logic dp_e, input logic fr_e);
    tick_chk({tag, "/dead"}, 4'b1111, dig_e, 1'b1, 1'b0);
    tick_chk({tag, "/c1"}, an_e, dig_e, dp_e, 1'b0);
    tick_chk({tag, "/c2"}, an_e, dig_e, dp_e, 1'b0);
    tick_chk({tag, "/c3"}, an_e, dig_e, dp_e, fr_e);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; value = v; dp_in = d;
  endtask

  initial begin
    // 1. Asynchronous reset with no clock edge.
    #1 rst = 1'b1;
    #1 chk_out("rst_init", 4'b1111, 4'h0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // F0: display is all zero. The load lands in slot 1 and is held until the frame wraps.
    slot("f0s0", 4'b1110, 4'h0, 1'b1, 1'b0);
    do_load(16'h1234, 4'b0010);
    slot("f0s1", 4'b1101, 4'h0, 1'b1, 1'b0);
    slot("f0s2", 4'b1011, 4'h0, 1'b1, 1'b0);
    slot("f0s3", 4'b0111, 4'h0, 1'b1, 1'b1);

    // F1: 2. basic scan of 0x1234; dp lit on digit 1 only.
    slot("f1s0", 4'b1110, 4'h4, 1'b1, 1'b0);
    slot("f1s1", 4'b1101, 4'h3, 1'b0, 1'b0);
    lz_blank = 1'b1;
    do_load(16'h0050, 4'b0000);
    slot("f1s2", 4'b1011, 4'h2, 1'b1, 1'b0);
    slot("f1s3", 4'b0111, 4'h1, 1'b1, 1'b1);

    // F2: 3. leading-zero blanking of 0x0050.
    slot("f2s0", 4'b1110, 4'h0, 1'b1, 1'b0);
    do_load(16'h0000, 4'b0000);
    slot("f2s1", 4'b1101, 4'h5, 1'b1, 1'b0);
    slot("f2s2", 4'b1111, 4'h0, 1'b1, 1'b0);
    slot("f2s3", 4'b1111, 4'h0, 1'b1, 1'b1);

    // F3: 0x0000 lights only digit 0.
    slot("f3s0", 4'b1110, 4'h0, 1'b1, 1'b0);
    do_load(16'h1000, 4'b0000);
    slot("f3s1", 4'b1111, 4'h0, 1'b1, 1'b0);
    slot("f3s2", 4'b1111, 4'h0, 1'b1, 1'b0);
    slot("f3s3", 4'b1111, 4'h0, 1'b1, 1'b1);

    // F4: 0x1000 lights all four digits. 4. A double load follows, and the last load wins.
    slot("f4s0", 4'b1110, 4'h0, 1'b1, 1'b0);
    do_load(16'hAAAA, 4'b0000);
    lz_blank = 1'b0;
    slot("f4s1", 4'b1101, 4'h0, 1'b1, 1'b0);
    do_load(16'hBBBB, 4'b1001);
    slot("f4s2", 4'b1011, 4'h0, 1'b1, 1'b0);
    slot("f4s3", 4'b0111, 4'h1, 1'b1, 1'b1);

    // F5: 0xBBBB, with dp on digits 0 and 3. 5. A stale pending value is replaced by a load on the wrap edge.
    slot("f5s0", 4'b1110, 4'hB, 1'b0, 1'b0);
    do_load(16'h1111, 4'b1111);
    slot("f5s1", 4'b1101, 4'hB, 1'b1, 1'b0);
    slot("f5s2", 4'b1011, 4'hB, 1'b1, 1'b0);
    tick_chk("f5s3/dead", 4'b1111, 4'hB, 1'b1, 1'b0);
    tick_chk("f5s3/c1", 4'b0111, 4'hB, 1'b0, 1'b0);
    tick_chk("f5s3/c2", 4'b0111, 4'hB, 1'b0, 1'b0);
    do_load(16'hC3C3, 4'b0100);
    tick_chk("f5s3/c3", 4'b0111, 4'hB, 1'b0, 1'b1);

    // F6: 0xC3C3 appears in the same swap; 0x1111 never appears.
    slot("f6s0", 4'b1110, 4'h3, 1'b1, 1'b0);
    do_load(16'h5678, 4'b0000);
    slot("f6s1", 4'b1101, 4'hC, 1'b1, 1'b0);
    slot("f6s2", 4'b1011, 4'h3, 1'b0, 1'b0);
    slot("f6s3", 4'b0111, 4'hC, 1'b1, 1'b1);

    // F7: 0x5678 is active and 0x9999 is pending. 6. Reset is asserted mid-frame.
    slot("f7s0", 4'b1110, 4'h8, 1'b1, 1'b0);
    do_load(16'h9999, 4'b1111);
    slot("f7s1", 4'b1101, 4'h7, 1'b1, 1'b0);
    tick_chk("f7s2/dead", 4'b1111, 4'h6, 1'b1, 1'b0);
    rst = 1'b1;
    #2 chk_out("rst_mid", 4'b1111, 4'h0, 1'b1, 1'b0);
    tick_chk("rst_hold", 4'b1111, 4'h0, 1'b1, 1'b0);
    rst = 1'b0;

    // Two frames of zeros follow. The discarded 0x9999 must not appear.
    slot("f8s0", 4'b1110, 4'h0, 1'b1, 1'b0);
    slot("f8s1", 4'b1101, 4'h0, 1'b1, 1'b0);
    slot("f8s2", 4'b1011, 4'h0, 1'b1, 1'b0);
    slot("f8s3", 4'b0111, 4'h0, 1'b1, 1'b1);
    slot("f9s0", 4'b1110, 4'h0, 1'b1, 1'b0);
    slot("f9s1", 4'b1101, 4'h0, 1'b1, 1'b0);
    slot("f9s2", 4'b1011, 4'h0, 1'b1, 1'b0);
    slot("f9s3", 4'b0111, 4'h0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
